atm_input_conditioner: RTL and testbench

Front-end stage that sits directly upstream of the ATM controller FSM. It converts raw, asynchronous board inputs into clean synchronous signals for the controller:
- BTN3/BTN2/BTN1 become single-cycle press pulses.
- The 4-bit SW bank becomes a debounced, stable value.
This guarantees one controller action per physical press, and a password or amount that does not change under a button event.

---
 rtl/atm_pkg.sv | 18 +
 rtl/atm_input_conditioner_if.sv | 29 ++
 rtl/btn_debounce.sv | 86 ++++++++
 rtl/atm_input_conditioner.sv | 92 +++++++++
 tb/tb_atm_input_conditioner.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/atm_pkg.sv
// Shared types and defaults for the ATM input conditioner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package atm_pkg;

    // Per-button debounce FSM encoding; bit 1 doubles as the debounced level.
    typedef enum logic [1:0] {
        BTN_RELEASED     = 2'd0,
        BTN_PRESS_WAIT   = 2'd1,
        BTN_PRESSED      = 2'd2,
        BTN_RELEASE_WAIT = 2'd3
    } btn_state_t;

    // Simulation-friendly default; the board build overrides with 500000.
    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int CNT_W_DEF           = 20;

endpackage

// File: rtl/atm_input_conditioner_if.sv
// Bundle of raw board inputs and conditioned outputs of the input conditioner.
// Latency: n/a (wires only).
// Backpressure: none; every signal is a plain level or pulse.
interface atm_input_conditioner_if;

    logic       BTN3;
    logic       BTN2;
    logic       BTN1;
    logic [3:0] SW;
    logic       btn3_pulse;
    logic       btn2_pulse;
    logic       btn1_pulse;
    logic [2:0] btn_level;
    logic [3:0] sw_stable;
    logic       any_pulse;

    // Board / stimulus side: drives raw inputs, observes conditioned outputs.
    modport master (
        output BTN3, BTN2, BTN1, SW,
        input  btn3_pulse, btn2_pulse, btn1_pulse, btn_level, sw_stable, any_pulse
    );

    // Conditioner side.
    modport slave (
        input  BTN3, BTN2, BTN1, SW,
        output btn3_pulse, btn2_pulse, btn1_pulse, btn_level, sw_stable, any_pulse
    );

endinterface

// File: rtl/btn_debounce.sv
// One push-button channel: 2-flop synchronizer, debounce FSM, press pulse and level.
// Latency: raw first sampled high at edge k -> pulse for the cycle after edge k+D+2.
// Backpressure: none; one pulse per accepted press, no auto-repeat.
module btn_debounce
    import atm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pulse,
    output logic press_fire,
    output logic level,
    output logic press_wait
);

    localparam logic [CNT_W-1:0] D = CNT_W'(DEBOUNCE_CYCLES);

    logic [1:0]       sync_q;
    logic             synced;
    btn_state_t       state;
    logic [CNT_W-1:0] cnt;

    assign synced = sync_q[1];

    // Press is accepted when a full run of D stable-high cycles has been counted.
    assign press_fire = (state == BTN_PRESS_WAIT) && synced && (cnt >= D);
    assign level      = state[1];
    assign press_wait = (state == BTN_PRESS_WAIT);

    // Synchronizer, debounce FSM, saturating run counter and registered press pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b00;
            state  <= BTN_RELEASED;
            cnt    <= '0;
            pulse  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], raw};
            pulse  <= press_fire;
            case (state)
                BTN_RELEASED: begin
                    if (synced) begin
                        state <= BTN_PRESS_WAIT;
                        cnt   <= CNT_W'(1);
                    end else begin
                        cnt   <= '0;
                    end
                end
                BTN_PRESS_WAIT: begin
                    if (!synced) begin
                        state <= BTN_RELEASED;
                        cnt   <= '0;
                    end else if (cnt >= D) begin
                        state <= BTN_PRESSED;
                        cnt   <= '0;
                    end else begin
                        cnt   <= cnt + CNT_W'(1);
                    end
                end
                BTN_PRESSED: begin
                    if (!synced) begin
                        state <= BTN_RELEASE_WAIT;
                        cnt   <= CNT_W'(1);
                    end else begin
                        cnt   <= '0;
                    end
                end
                BTN_RELEASE_WAIT: begin
                    if (synced) begin
                        state <= BTN_PRESSED;
                        cnt   <= '0;
                    end else if (cnt >= D) begin
                        state <= BTN_RELEASED;
                        cnt   <= '0;
                    end else begin
                        cnt   <= cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/atm_input_conditioner.sv
// Board-input front end: three debounced press-pulse buttons plus a debounced switch bank.
// Latency: pulses at edge k+D+2 after first raw sample; switches settle D+3 edges after change.
// Backpressure: none; switch updates are held off while a button press is being qualified.
module atm_input_conditioner
    import atm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    atm_input_conditioner_if.slave io
);

    localparam logic [CNT_W-1:0] D = CNT_W'(DEBOUNCE_CYCLES);

    logic [2:0] raw_vec;
    logic [2:0] pulse_vec;
    logic [2:0] fire_vec;
    logic [2:0] level_vec;
    logic [2:0] pw_vec;
    logic       any_pulse_q;

    logic [3:0]       sw_s1;
    logic [3:0]       sw_s2;
    logic [3:0]       sw_prev;
    logic [CNT_W-1:0] sw_cnt;
    logic [3:0]       sw_stable_q;
    logic             sw_freeze;

    assign raw_vec = {io.BTN3, io.BTN2, io.BTN1};

    for (genvar i = 0; i < 3; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_btn (
            .clk        (clk),
            .rst        (rst),
            .raw        (raw_vec[i]),
            .pulse      (pulse_vec[i]),
            .press_fire (fire_vec[i]),
            .level      (level_vec[i]),
            .press_wait (pw_vec[i])
        );
    end

    // Keep the switch value fixed while any press is in flight or being delivered,
    // so the controller never sees the operand change under a button event.
    assign sw_freeze = any_pulse_q | (|pw_vec);

    // any_pulse is built from the channels' next-pulse terms so it lines up with them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            any_pulse_q <= 1'b0;
        end else begin
            any_pulse_q <= |fire_vec;
        end
    end

    // Switch synchronizer, stability counter and frozen-aware stable-value register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_s1       <= 4'h0;
            sw_s2       <= 4'h0;
            sw_prev     <= 4'h0;
            sw_cnt      <= '0;
            sw_stable_q <= 4'h0;
        end else begin
            sw_s1   <= io.SW;
            sw_s2   <= sw_s1;
            sw_prev <= sw_s2;
            if (sw_s2 != sw_prev) begin
                sw_cnt <= '0;
            end else if (sw_cnt < D) begin
                sw_cnt <= sw_cnt + CNT_W'(1);
            end
            // The equality term stops a fresh change from riding on a saturated count.
            if (!sw_freeze && (sw_s2 == sw_prev) && (sw_cnt >= D) && (sw_s2 != sw_stable_q)) begin
                sw_stable_q <= sw_s2;
            end
        end
    end

    assign io.btn3_pulse = pulse_vec[2];
    assign io.btn2_pulse = pulse_vec[1];
    assign io.btn1_pulse = pulse_vec[0];
    assign io.btn_level  = level_vec;
    assign io.sw_stable  = sw_stable_q;
    assign io.any_pulse  = any_pulse_q;

endmodule

// File: tb/tb_atm_input_conditioner.sv
// Directed bench for the ATM input conditioner with DEBOUNCE_CYCLES = 4.
// Inputs change #1 after a rising edge; the following rising edge is "edge k".
// Outputs are checked #1 after rising edges.
module tb_atm_input_conditioner;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int checks = 0;
    int passed = 0;
    int failed = 0;

    int p3 = 0;
    int p2 = 0;
    int p1 = 0;
    int pa = 0;
    int base;

    atm_input_conditioner_if bus ();

    atm_input_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (20)
    ) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    always #5 clk = ~clk;

    wire [11:0] outs = {bus.btn3_pulse, bus.btn2_pulse, bus.btn1_pulse,
                        bus.btn_level, bus.sw_stable, bus.any_pulse};
    wire [2:0]  pulses = {bus.btn3_pulse, bus.btn2_pulse, bus.btn1_pulse};

    // Pulse tallies, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.btn3_pulse) p3 = p3 + 1;
        if (bus.btn2_pulse) p2 = p2 + 1;
        if (bus.btn1_pulse) p1 = p1 + 1;
        if (bus.any_pulse)  pa = pa + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) passed = passed + 1;
        else begin
            failed = failed + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.BTN3 = 1'b0;
        bus.BTN2 = 1'b0;
        bus.BTN1 = 1'b0;
        bus.SW   = 4'h0;

        // Reset state
        #12;
        check("reset_outs", outs, 12'h000);
        tick(2);
        rst = 1'b1;
        check("release_outs", outs, 12'h000);
        tick(1);
        check("first_cycle_outs", outs, 12'h000);
        tick(3);

        // BTN3 press held 40 cycles: one pulse at edge k+6, level from k+6
        bus.BTN3 = 1'b1;
        tick(6);
        check("b3_pre_pulse", bus.btn3_pulse, 1'b0);
        check("b3_pre_level", bus.btn_level, 3'b000);
        tick(1);
        check("b3_pulse", bus.btn3_pulse, 1'b1);
        check("b3_level", bus.btn_level, 3'b100);
        check("b3_any", bus.any_pulse, 1'b1);
        tick(1);
        check("b3_pulse_drop", bus.btn3_pulse, 1'b0);
        check("b3_any_drop", bus.any_pulse, 1'b0);
        base = p3;
        tick(38);
        check("b3_hold_no_repeat", p3 - base, 0);
        check("b3_hold_level", bus.btn_level, 3'b100);
        bus.BTN3 = 1'b0;
        tick(10);
        check("b3_release_level", bus.btn_level, 3'b000);
        check("b3_release_no_pulse", p3 - base, 0);

        // BTN2 bounce 1,0,1,0 then steady high
        bus.BTN2 = 1'b1; tick(1);
        bus.BTN2 = 1'b0; tick(1);
        bus.BTN2 = 1'b1; tick(1);
        bus.BTN2 = 1'b0; tick(6);
        check("b2_bounce_no_pulse", p2, 0);
        check("b2_bounce_level", bus.btn_level, 3'b000);
        bus.BTN2 = 1'b1;
        tick(6);
        check("b2_pre_pulse", bus.btn2_pulse, 1'b0);
        tick(1);
        check("b2_pulse", bus.btn2_pulse, 1'b1);
        tick(1);
        check("b2_pulse_count", p2, 1);
        bus.BTN2 = 1'b0;
        tick(10);

        // BTN1 press, 2-cycle release glitch, clean release, re-press
        bus.BTN1 = 1'b1;
        tick(7);
        check("b1_pulse", bus.btn1_pulse, 1'b1);
        tick(3);
        bus.BTN1 = 1'b0; tick(2);
        bus.BTN1 = 1'b1; tick(4);
        check("b1_glitch_level", bus.btn_level, 3'b001);
        tick(4);
        check("b1_glitch_no_pulse", p1, 1);
        bus.BTN1 = 1'b0;
        tick(10);
        check("b1_clean_release", bus.btn_level, 3'b000);
        bus.BTN1 = 1'b1;
        tick(7);
        check("b1_repress_pulse", bus.btn1_pulse, 1'b1);
        tick(1);
        check("b1_pulse_count", p1, 2);
        bus.BTN1 = 1'b0;
        tick(10);

        // SW 0000->0101 settling under a BTN3 press window
        bus.SW   = 4'h5;
        bus.BTN3 = 1'b1;
        tick(7);
        check("sw_frozen_pulse_cycle", {bus.btn3_pulse, bus.sw_stable}, {1'b1, 4'h0});
        tick(1);
        check("sw_frozen_after_pulse", bus.sw_stable, 4'h0);
        tick(1);
        check("sw_update_free", bus.sw_stable, 4'h5);
        bus.BTN3 = 1'b0;
        tick(10);

        // Unfrozen SW change 0101->1010 lands at edge k+7
        bus.SW = 4'hA;
        tick(7);
        check("sw_unfrozen_pre", bus.sw_stable, 4'h5);
        tick(1);
        check("sw_unfrozen_update", bus.sw_stable, 4'hA);
        // Short SW glitch is ignored
        bus.SW = 4'hF; tick(2);
        bus.SW = 4'hA; tick(12);
        check("sw_glitch_ignored", bus.sw_stable, 4'hA);

        // Reset while BTN3 held in PRESSED
        bus.BTN3 = 1'b1;
        tick(10);
        check("rst_pre_level", bus.btn_level, 3'b100);
        base = p3;
        rst = 1'b0;
        #1;
        check("rst_async_outs", outs, 12'h000);
        tick(3);
        check("rst_held_outs", outs, 12'h000);
        rst = 1'b1;
        check("rst_release_outs", outs, 12'h000);
        tick(6);
        check("rst_edge5_no_pulse", {bus.btn3_pulse, bus.btn_level}, 4'h0);
        tick(1);
        check("rst_edge6_pulse", bus.btn3_pulse, 1'b1);
        tick(1);
        check("rst_single_pulse", p3 - base, 1);
        bus.BTN3 = 1'b0;
        tick(10);

        // BTN3 and BTN1 raised on the same edge
        base = pa;
        bus.BTN3 = 1'b1;
        bus.BTN1 = 1'b1;
        tick(7);
        check("dual_pulses", pulses, 3'b101);
        check("dual_any", bus.any_pulse, 1'b1);
        tick(1);
        check("dual_any_drop", bus.any_pulse, 1'b0);
        check("dual_any_count", pa - base, 1);
        bus.BTN3 = 1'b0;
        bus.BTN1 = 1'b0;
        tick(4);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
